gpr_bank: RTL and testbench
===========================

GPR_BANK -- requirements
Module: gpr_bank

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, meaning the width of each register.
REQ-002 The module SHALL have parameter ADDR_W, default 3, meaning the address width; DEPTH = 2**ADDR_W entries.
REQ-003 The module SHALL have parameter ZERO_REG, default 0; when 1, entry 0 always reads zero and writes to it are discarded.
REQ-004 Port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 Port clr, input, 1, meaning reset: asynchronous, active-high.
REQ-006 Port wr_en, input, 1, meaning the write strobe.
REQ-007 Port wr_addr, input, ADDR_W, meaning the write destination.
REQ-008 Port wr_data, input, DATA_W, meaning the write data.
REQ-009 Ports rd_addr_a and rd_addr_b, input, ADDR_W each, meaning the read addresses.
REQ-010 Ports rd_data_a and rd_data_b, output, DATA_W each, meaning the read data.
REQ-011 Port iss_en, input, 1, meaning the issue strobe that marks a register pending.
REQ-012 Port iss_addr, input, ADDR_W, meaning the register being marked pending.
REQ-013 Ports busy_a and busy_b, output, 1 each, meaning the pending flag of rd_addr_a and rd_addr_b.
REQ-014 Port flush_req, input, 1, meaning a request for a sequenced clear of all entries.
REQ-015 Port flush_busy, output, 1, meaning a flush is in progress.

Function
REQ-016 Reads SHALL be combinational: rd_data_x = entry[rd_addr_x], with zero latency.
REQ-017 Write-through bypass SHALL apply in IDLE: when wr_en=1 and wr_addr==rd_addr_x, rd_data_x = wr_data in the same cycle.
REQ-018 With ZERO_REG=1, reads of address 0 SHALL return 0, bypass included, and busy for address 0 SHALL always be 0.
REQ-019 In IDLE, wr_en=1 SHALL update entry[wr_addr] at the next edge.
REQ-020 The scoreboard SHALL hold one busy bit per entry; iss_en sets busy[iss_addr] and wr_en clears busy[wr_addr] at the next edge.
REQ-021 When iss_en and wr_en target the same address in the same cycle, set SHALL win: the busy bit ends at 1 and the data is still written.
REQ-022 busy_x SHALL be combinational from the busy bits, with no bypass: a same-cycle clear or set is visible only after the edge.
REQ-023 The FSM SHALL have two states, IDLE and FLUSH; flush_req=1 in IDLE moves to FLUSH at the next edge with counter fcnt=0.
REQ-024 In FLUSH, each cycle SHALL zero entry[fcnt] and busy[fcnt], then increment fcnt; after fcnt==DEPTH-1 the FSM returns to IDLE.
REQ-025 A flush SHALL therefore take exactly DEPTH cycles with flush_busy=1, and flush_busy SHALL be registered (high from the first cycle after acceptance).
REQ-026 In FLUSH, wr_en, iss_en and flush_req SHALL be ignored, and bypass is disabled; reads return current array contents.
REQ-027 flush_req asserted in the cycle the FSM returns to IDLE SHALL be ignored; only a request sampled in IDLE starts a flush.
REQ-028 fcnt SHALL be ADDR_W bits wide and wrap to 0 on exit, with no extra terminal cycle.

Reset
REQ-029 clr=1 SHALL asynchronously zero all entries and busy bits, set the FSM to IDLE, fcnt to 0 and flush_busy to 0.
REQ-030 clr asserted mid-flush SHALL abort the flush immediately, with the reset values above.
REQ-031 After clr deasserts, the first rising edge SHALL operate normally.

Structure
REQ-032 The shared package SHALL hold the FSM state enum (IDLE, FLUSH) and the default DATA_W and ADDR_W constants.
REQ-033 The scoreboard SHALL be a sub-module gpr_scoreboard (busy bits, set/clear priority, flush clear, two lookup ports); the array, bypass and FSM remain in gpr_bank.

Verification
REQ-034 Write then read: wr 0x1234 to r5, next cycle rd_addr_a=5 -> rd_data_a=0x1234.
REQ-035 Bypass: wr_en=1, wr_addr=3, wr_data=0xBEEF, rd_addr_b=3 in the same cycle -> rd_data_b=0xBEEF before the edge.
REQ-036 Scoreboard: iss r2, next cycle busy_a=1 (rd_addr_a=2); wr r2 with iss r2 in the same cycle -> busy stays 1; wr r2 alone -> busy 0 next cycle.
REQ-037 Flush: load r0..r7 with 1..8 and flush_req for 1 cycle -> flush_busy high for exactly 8 cycles, a wr during it is dropped, all reads are 0 afterward.
REQ-038 ZERO_REG=1: wr 0xFFFF to r0 -> rd r0=0, including bypass, and busy stays 0 after iss r0.
REQ-039 Reset mid-flush: assert clr at fcnt=3 -> flush_busy=0 immediately, all entries and busy bits 0; a write on the next edge is accepted.

Source files
------------

// File: rtl/gpr_bank_pkg.sv
// Shared definitions for the general-purpose register bank: default widths
// and the flush sequencer state type.
package gpr_bank_pkg;

    localparam int GPR_DATA_W = 16;
    localparam int GPR_ADDR_W = 3;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } gpr_state_e;

endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue and
// cleared on writeback, with a per-entry clear used by the flush sequencer.
module gpr_scoreboard
    import gpr_bank_pkg::*;
#(
    parameter int ADDR_W   = GPR_ADDR_W,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              rel_en,
    input  logic [ADDR_W-1:0] rel_addr,
    input  logic              flush_en,
    input  logic [ADDR_W-1:0] flush_addr,
    input  logic [ADDR_W-1:0] look_addr_a,
    input  logic [ADDR_W-1:0] look_addr_b,
    output logic              busy_a,
    output logic              busy_b
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Release is applied before set so a same-cycle issue to the register
    // being written back leaves it pending.
    always_comb begin
        busy_d = busy_q;
        if (flush_en) begin
            busy_d[flush_addr] = 1'b0;
        end else begin
            if (rel_en) busy_d[rel_addr] = 1'b0;
            if (set_en) busy_d[set_addr] = 1'b1;
        end
        if (ZR) busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // No bypass: lookups reflect only the registered bits.
    assign busy_a = busy_q[look_addr_a];
    assign busy_b = busy_q[look_addr_b];

endmodule

// File: rtl/gpr_bank.sv
// Two-read/one-write register bank with write-through bypass, a pending
// scoreboard and a one-entry-per-cycle flush sequencer.
module gpr_bank
    import gpr_bank_pkg::*;
#(
    parameter int DATA_W   = GPR_DATA_W,
    parameter int ADDR_W   = GPR_ADDR_W,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              flush_req,
    output logic              flush_busy
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam bit                ZR       = (ZERO_REG != 0);

    gpr_state_e        state_q;
    logic [ADDR_W-1:0] fcnt_q;
    logic              flush_busy_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic idle;
    logic wr_ok;
    logic iss_ok;
    logic flushing;

    assign idle       = (state_q == ST_IDLE);
    assign flushing   = (state_q == ST_FLUSH);
    assign wr_ok      = idle && wr_en;
    assign iss_ok     = idle && iss_en;
    assign flush_busy = flush_busy_q;

    // Flush sequencer: acceptance only from IDLE, exit straight after the
    // last entry so the counter wraps back to zero on its own.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            fcnt_q       <= '0;
            flush_busy_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (flush_req) begin
                        state_q      <= ST_FLUSH;
                        fcnt_q       <= '0;
                        flush_busy_q <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    fcnt_q <= fcnt_q + 1'b1;
                    if (fcnt_q == LAST_IDX) begin
                        state_q      <= ST_IDLE;
                        flush_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    fcnt_q       <= '0;
                    flush_busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flushing) begin
            mem_q[fcnt_q] <= '0;
        end else if (wr_ok && !(ZR && wr_addr == '0)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Bypass only while IDLE; a hardwired zero register overrides everything.
    always_comb begin
        rd_data_a = mem_q[rd_addr_a];
        if (wr_ok && wr_addr == rd_addr_a) rd_data_a = wr_data;
        if (ZR && rd_addr_a == '0) rd_data_a = '0;
    end

    always_comb begin
        rd_data_b = mem_q[rd_addr_b];
        if (wr_ok && wr_addr == rd_addr_b) rd_data_b = wr_data;
        if (ZR && rd_addr_b == '0) rd_data_b = '0;
    end

    gpr_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .clr         (clr),
        .set_en      (iss_ok),
        .set_addr    (iss_addr),
        .rel_en      (wr_ok),
        .rel_addr    (wr_addr),
        .flush_en    (flushing),
        .flush_addr  (fcnt_q),
        .look_addr_a (rd_addr_a),
        .look_addr_b (rd_addr_b),
        .busy_a      (busy_a),
        .busy_b      (busy_b)
    );

endmodule

// File: tb/tb_gpr_bank.sv
// Bench for gpr_bank: two instances (plain and hardwired-zero r0) share one
// stimulus stream and are compared every cycle against an array model.
`timescale 1ns/1ps
module tb_gpr_bank;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk       = 1'b0;
    logic          clr       = 1'b0;
    logic          wr_en     = 1'b0;
    logic [AW-1:0] wr_addr   = '0;
    logic [DW-1:0] wr_data   = '0;
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic          iss_en    = 1'b0;
    logic [AW-1:0] iss_addr  = '0;
    logic          flush_req = 1'b0;

    logic [DW-1:0] rd_a0, rd_b0, rd_a1, rd_b1;
    logic          busy_a0, busy_b0, busy_a1, busy_b1;
    logic          fb0, fb1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Model: register contents and pending flags per instance (0 = plain,
    // 1 = hardwired-zero r0), plus the flush progress.
    logic [DW-1:0] m_reg  [2][DEPTH];
    bit            m_busy [2][DEPTH];
    int            m_fleft = 0;
    int            m_fptr  = 0;

    gpr_bank #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut0 (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_a0), .rd_data_b(rd_b0),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_a(busy_a0), .busy_b(busy_b0),
        .flush_req(flush_req), .flush_busy(fb0)
    );

    gpr_bank #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut1 (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_a1), .rd_data_b(rd_b1),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_a(busy_a1), .busy_b(busy_b1),
        .flush_req(flush_req), .flush_busy(fb1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_reg[z][i]  = '0;
                m_busy[z][i] = 1'b0;
            end
        end
        m_fleft = 0;
        m_fptr  = 0;
    endtask

    function automatic logic [DW-1:0] exp_rd(input int z, input logic [AW-1:0] a);
        if (z == 1 && a == 0) return '0;
        if (m_fleft == 0 && wr_en && wr_addr == a) return wr_data;
        return m_reg[z][a];
    endfunction

    function automatic logic exp_busy(input int z, input logic [AW-1:0] a);
        if (z == 1 && a == 0) return 1'b0;
        return m_busy[z][a];
    endfunction

    always @(posedge clk) begin
        if (clr) begin
            m_reset();
        end else if (m_fleft > 0) begin
            for (int z = 0; z < 2; z++) begin
                m_reg[z][m_fptr]  = '0;
                m_busy[z][m_fptr] = 1'b0;
            end
            m_fptr++;
            m_fleft--;
        end else begin
            for (int z = 0; z < 2; z++) begin
                if (wr_en && !(z == 1 && wr_addr == 0)) m_reg[z][wr_addr] = wr_data;
                if (wr_en) m_busy[z][wr_addr] = 1'b0;
                if (iss_en && !(z == 1 && iss_addr == 0)) m_busy[z][iss_addr] = 1'b1;
            end
            if (flush_req) begin
                m_fleft = DEPTH;
                m_fptr  = 0;
            end
        end
    end

    // Per-cycle compare, after the negedge input update has settled.
    always @(negedge clk) begin
        #2;
        if (chk_on) begin
            chk("rd_a_plain", 32'(rd_a0), 32'(exp_rd(0, rd_addr_a)));
            chk("rd_b_plain", 32'(rd_b0), 32'(exp_rd(0, rd_addr_b)));
            chk("rd_a_zr",    32'(rd_a1), 32'(exp_rd(1, rd_addr_a)));
            chk("rd_b_zr",    32'(rd_b1), 32'(exp_rd(1, rd_addr_b)));
            chk("busy_a_plain", 32'(busy_a0), 32'(exp_busy(0, rd_addr_a)));
            chk("busy_b_plain", 32'(busy_b0), 32'(exp_busy(0, rd_addr_b)));
            chk("busy_a_zr",    32'(busy_a1), 32'(exp_busy(1, rd_addr_a)));
            chk("busy_b_zr",    32'(busy_b1), 32'(exp_busy(1, rd_addr_b)));
            chk("flush_busy_plain", 32'(fb0), 32'(m_fleft > 0));
            chk("flush_busy_zr",    32'(fb1), 32'(m_fleft > 0));
        end
    end

    task automatic quiet();
        wr_en     = 1'b0;
        iss_en    = 1'b0;
        flush_req = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        m_reset();
        #2 clr = 1'b1;
        m_reset();
        chk_on = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #3;
        chk("reset_rd_a", 32'(rd_a0), 32'h0);
        chk("reset_flush_busy", 32'(fb0), 32'h0);
        clr = 1'b0;

        // Write then read
        @(negedge clk); quiet(); wr_en = 1; wr_addr = 5; wr_data = 16'h1234;
        @(negedge clk); quiet(); rd_addr_a = 5;
        #3 chk("wr_then_rd", 32'(rd_a0), 32'h1234);
        chk("model_r5", 32'(m_reg[0][5]), 32'h1234);

        // Same-cycle bypass
        @(negedge clk); quiet(); wr_en = 1; wr_addr = 3; wr_data = 16'hBEEF; rd_addr_b = 3;
        #3 chk("bypass_b", 32'(rd_b0), 32'hBEEF);
        chk("bypass_b_zr", 32'(rd_b1), 32'hBEEF);

        // Scoreboard set / set-wins / clear
        @(negedge clk); quiet(); iss_en = 1; iss_addr = 2; rd_addr_a = 2;
        #3 chk("busy_before_iss", 32'(busy_a0), 32'h0);
        @(negedge clk); quiet(); iss_en = 1; iss_addr = 2; wr_en = 1; wr_addr = 2; wr_data = 16'h5555;
        #3 chk("busy_after_iss", 32'(busy_a0), 32'h1);
        @(negedge clk); quiet(); wr_en = 1; wr_addr = 2; wr_data = 16'h6666;
        #3 chk("busy_set_wins", 32'(busy_a0), 32'h1);
        @(negedge clk); quiet();
        #3 chk("busy_cleared", 32'(busy_a0), 32'h0);
        chk("rd_r2_after_wr", 32'(rd_a0), 32'h6666);

        // Hardwired zero register
        @(negedge clk); quiet(); wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF; rd_addr_a = 0;
        #3 chk("zr_bypass", 32'(rd_a1), 32'h0);
        chk("plain_r0_bypass", 32'(rd_a0), 32'hFFFF);
        @(negedge clk); quiet(); iss_en = 1; iss_addr = 0;
        #3 chk("zr_rd_r0", 32'(rd_a1), 32'h0);
        @(negedge clk); quiet();
        #3 chk("zr_busy_r0", 32'(busy_a1), 32'h0);
        chk("plain_busy_r0", 32'(busy_a0), 32'h1);

        // Flush: load 1..8, request held through the flush, write attempted mid-way
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); quiet(); wr_en = 1; wr_addr = AW'(i); wr_data = DW'(i + 1);
        end
        @(negedge clk); quiet(); flush_req = 1; rd_addr_a = 7; rd_addr_b = 6;
        #3 chk("loaded_r7", 32'(rd_a0), 32'h8);
        chk("flush_busy_at_accept", 32'(fb0), 32'h0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fb0) begin
                cnt++;
                quiet();
                flush_req = 1;
                if (k == 2) begin
                    wr_en = 1; wr_addr = 6; wr_data = 16'hAAAA;
                    iss_en = 1; iss_addr = 6;
                end
            end else begin
                quiet();
                break;
            end
        end
        #3 chk("flush_cycles", 32'(cnt), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); quiet(); rd_addr_a = AW'(i); rd_addr_b = AW'(i);
            #3 chk("post_flush_rd", 32'(rd_a0), 32'h0);
            chk("post_flush_busy", 32'(busy_b0), 32'h0);
        end

        // Reset in the middle of a flush (entry 3 being cleared)
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); quiet(); wr_en = 1; wr_addr = AW'(i); wr_data = DW'(16'h100 + i);
            iss_en = 1; iss_addr = AW'(i ^ 1);
        end
        @(negedge clk); quiet(); flush_req = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); quiet();
        end
        clr = 1'b1;
        m_reset();
        #1 chk("clr_mid_flush_busy", 32'(fb0), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk); rd_addr_a = AW'(i); rd_addr_b = AW'(i);
            #3 chk("clr_rd", 32'(rd_a0), 32'h0);
            chk("clr_busy", 32'(busy_b0), 32'h0);
        end
        @(negedge clk); clr = 1'b0; quiet(); wr_en = 1; wr_addr = 4; wr_data = 16'h4321;
        @(negedge clk); quiet(); rd_addr_a = 4;
        #3 chk("wr_after_clr", 32'(rd_a0), 32'h4321);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (clr) begin
                clr = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                clr = 1'b1;
                m_reset();
            end
            wr_en     = ($urandom_range(0, 2) != 0);
            wr_addr   = AW'($urandom);
            wr_data   = DW'($urandom);
            iss_en    = ($urandom_range(0, 2) == 0);
            iss_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom);
            rd_addr_b = AW'($urandom);
            flush_req = ($urandom_range(0, 39) == 0);
        end

        @(negedge clk); quiet(); clr = 1'b0;
        @(negedge clk);
        #3 chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
